regfile_fwd: RTL
================

# regfile_fwd

Architectural register file for the five-stage MIPS pipeline, with built-in operand forwarding. It holds the 32×32 general-purpose registers, takes its write port from the write-back stage, and serves the two decode-stage read ports. Each read resolves RAW hazards by priority: EX-stage result, then MEM-stage result, then the same-cycle write-back, then the array. It is the consumer end of the `wd/wreg/wdata` result interface that the EX stage drives.

## Interface
Parameters:
- `NREG`, 32: number of registers; the address width follows as `RegAddrBus` (5 bits).
- `DW`, 32: data width, `RegBus`.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `we`, in, 1: write-back write enable.
- `waddr`, in, 5: write-back destination register.
- `wdata`, in, 32: write-back data.
- `ex_wreg`, in, 1: EX stage will write a register.
- `ex_wd`, in, 5: EX destination register.
- `ex_wdata`, in, 32: EX result.
- `mem_wreg`, in, 1: MEM stage will write a register.
- `mem_wd`, in, 5: MEM destination register.
- `mem_wdata`, in, 32: MEM result.
- `re1`, in, 1: read port 1 enable.
- `raddr1`, in, 5: read port 1 address.
- `rdata1`, out, 32: read port 1 data.
- `re2`, in, 1: read port 2 enable.
- `raddr2`, in, 5: read port 2 address.
- `rdata2`, out, 32: read port 2 data.
- `fwd1`, out, 2: read port 1 source. 0 = array, 1 = write-back, 2 = MEM, 3 = EX.
- `fwd2`, out, 2: read port 2 source, same encoding as `fwd1`.

## Operation
- Storage is an array of `NREG` × `DW` flops. Register 0 is hardwired to zero: a write to it is discarded and a read of it returns 0 with source code 0.
- Write rule: on the rising edge, if `rst` = 0, `we` = 1 and `waddr` ≠ 0, then `regs[waddr] <= wdata`.
- Reset: while `rst` = 1 at a rising edge, every register clears to 0, and any write on that edge is suppressed.
- Read path is combinational. For port n, the first matching condition applies:
  1. `rst` = 1, or `ren` = 0, or `raddrn` = 0: data 0, source 0.
  2. `ex_wreg` = 1 and `ex_wd` = `raddrn`: `ex_wdata`, source 3.
  3. `mem_wreg` = 1 and `mem_wd` = `raddrn`: `mem_wdata`, source 2.
  4. `we` = 1 and `waddr` = `raddrn`: `wdata`, source 1.
  5. Otherwise: `regs[raddrn]`, source 0.
- The two ports are fully independent. Both may hit the same address and the same forwarding source in one cycle.
- A forwarding source whose destination is 0 never matches, even when its write flag is 1.
- No X may propagate: a disabled port drives 0, never the array contents.

## Timing
- Read latency is 0 cycles (combinational from address, enables and forwarding inputs).
- Write latency is 1 cycle. Data is visible from the array on the cycle after the edge, and from the bypass in the same cycle.
- Reset values: all registers 0; `rdata1`/`rdata2` = 0 and `fwd1`/`fwd2` = 0 for as long as `rst` = 1.
- Reset mid-stream: a write presented on the same edge as `rst` = 1 is lost. The first write accepted is on the first edge with `rst` = 0.
- Forwarding priority resolves simultaneous hits. For example, EX, MEM and WB all targeting r5 returns the EX value.
- There are no stalls and no handshake. Load-use stalls are the decode stage's responsibility.

## Structure
- Shared `defines.v` additions (if absent): `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`, `ZeroWord`, `RstEnable`, `WriteEnable`, `ReadEnable`, and `FwdNone`/`FwdWb`/`FwdMem`/`FwdEx` (2'd0..2'd3).
- Sub-module `regfile_rdport` holds the priority mux for one read port. It takes the address, the enable, the three forwarding tuples and the array word, and returns data and source. It is instantiated twice.
- The array and write logic stay in the top module.

## Test plan
- **Reset clear:** write r7 = 0x1234_5678, then assert `rst` for 1 cycle, then read r7 → 0, `fwd` = 0. A write presented on the reset edge leaves r7 = 0.
- **r0 immunity:** `we` = 1, `waddr` = 0, `wdata` = 0xFFFF_FFFF, then read r0 → 0. Also `ex_wreg` = 1, `ex_wd` = 0, `ex_wdata` = 0xDEAD_BEEF, read r0 → 0, `fwd` = 0.
- **Write then read:** write r3 = 0xA5A5_0001. Reading r3 in the same cycle → 0xA5A5_0001, `fwd` = 1. Reading on the next cycle with `we` = 0 → 0xA5A5_0001, `fwd` = 0.
- **Priority:** array r5 = 0x11, WB writing 0x22, MEM 0x33, EX 0x44, all to r5. Read → 0x44/3. Drop EX → 0x33/2. Drop MEM → 0x22/1.
- **Dual port:** port 1 reads r8 with EX hitting r8 = 0x8, port 2 reads r9 from the array = 0x9. Expect 0x8/3 and 0x9/0 simultaneously. Then `re2` = 0 → `rdata2` = 0.
- **Random stream:** 10k cycles of random EX/MEM/WB traffic, checked against a reference model of pipeline commit order. Every read must equal the youngest in-flight value.

Source files
------------

// File: rtl/regfile_fwd_pkg.sv
// Shared constants for the register file with operand forwarding:
// bus widths, register count and the read-source encoding.
package regfile_fwd_pkg;

  localparam int RegBusW    = 32;
  localparam int RegAddrBusW = 5;
  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  localparam logic [RegBusW-1:0] ZeroWord = '0;

  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

  // Where a read port's data came from; also the encoding of fwd1/fwd2.
  typedef enum logic [1:0] {
    FwdNone = 2'd0,  // architectural array (or forced zero)
    FwdWb   = 2'd1,  // same-cycle write-back
    FwdMem  = 2'd2,  // MEM-stage result
    FwdEx   = 2'd3   // EX-stage result
  } fwd_src_e;

endpackage

// File: rtl/regfile_rdport.sv
// One decode-stage read port: resolves RAW hazards by picking the youngest
// in-flight producer of the requested register (EX > MEM > WB > array).
module regfile_rdport
  import regfile_fwd_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          rst,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          ex_wreg,
  input  logic [AW-1:0] ex_wd,
  input  logic [DW-1:0] ex_wdata,
  input  logic          mem_wreg,
  input  logic [AW-1:0] mem_wd,
  input  logic [DW-1:0] mem_wdata,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  input  logic [DW-1:0] arr_data,
  output logic [DW-1:0] rdata,
  output logic [1:0]    src
);

  // Priority select; raddr is known nonzero past the first branch, so a
  // producer targeting r0 can never match.
  always_comb begin
    rdata = '0;
    src   = FwdNone;
    if (rst == RstEnable || re != ReadEnable || raddr == '0) begin
      rdata = '0;
      src   = FwdNone;
    end else if (ex_wreg && ex_wd == raddr) begin
      rdata = ex_wdata;
      src   = FwdEx;
    end else if (mem_wreg && mem_wd == raddr) begin
      rdata = mem_wdata;
      src   = FwdMem;
    end else if (wb_we && wb_waddr == raddr) begin
      rdata = wb_wdata;
      src   = FwdWb;
    end else begin
      rdata = arr_data;
      src   = FwdNone;
    end
  end

endmodule

// File: rtl/regfile_fwd.sv
// Architectural register file (NREG x DW) with a write-back write port and
// two forwarding read ports. r0 is hardwired to zero.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int NREG = RegNum,
  parameter int DW   = RegBusW,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          ex_wreg,
  input  logic [AW-1:0] ex_wd,
  input  logic [DW-1:0] ex_wdata,
  input  logic          mem_wreg,
  input  logic [AW-1:0] mem_wd,
  input  logic [DW-1:0] mem_wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  output logic [1:0]    fwd1,
  output logic [1:0]    fwd2
);

  logic [DW-1:0] r_regs [NREG];
  logic [DW-1:0] w_arr1;
  logic [DW-1:0] w_arr2;

  // Register writes; reset clears everything and swallows a same-edge write.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we == WriteEnable && waddr != '0) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign w_arr1 = r_regs[raddr1];
  assign w_arr2 = r_regs[raddr2];

  regfile_rdport #(.AW(AW), .DW(DW)) u_rdport1 (
    .rst       (rst),
    .re        (re1),
    .raddr     (raddr1),
    .ex_wreg   (ex_wreg),
    .ex_wd     (ex_wd),
    .ex_wdata  (ex_wdata),
    .mem_wreg  (mem_wreg),
    .mem_wd    (mem_wd),
    .mem_wdata (mem_wdata),
    .wb_we     (we),
    .wb_waddr  (waddr),
    .wb_wdata  (wdata),
    .arr_data  (w_arr1),
    .rdata     (rdata1),
    .src       (fwd1)
  );

  regfile_rdport #(.AW(AW), .DW(DW)) u_rdport2 (
    .rst       (rst),
    .re        (re2),
    .raddr     (raddr2),
    .ex_wreg   (ex_wreg),
    .ex_wd     (ex_wd),
    .ex_wdata  (ex_wdata),
    .mem_wreg  (mem_wreg),
    .mem_wd    (mem_wd),
    .mem_wdata (mem_wdata),
    .wb_we     (we),
    .wb_waddr  (waddr),
    .wb_wdata  (wdata),
    .arr_data  (w_arr2),
    .rdata     (rdata2),
    .src       (fwd2)
  );

endmodule
